// File: rtl/data_mem_responder.sv
// Memory-side responder: one request at a time, programmable latency.
// Optional counters: define MEM_RESPONDER_STATS_EN.
module data_mem_responder #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_read_valid,
  input  logic [ADDR_BITS-1:0] mem_read_address,
  output logic                 mem_read_ready,
  output logic [DATA_BITS-1:0] mem_read_data,
  input  logic                 mem_write_valid,
  input  logic [ADDR_BITS-1:0] mem_write_address,
  input  logic [DATA_BITS-1:0] mem_write_data,
  output logic                 mem_write_ready,
  input  logic                 host_write_en,
  input  logic [ADDR_BITS-1:0] host_addr,
  input  logic [DATA_BITS-1:0] host_data,
`ifdef MEM_RESPONDER_STATS_EN
  output logic [15:0]          stat_reads,
  output logic [15:0]          stat_writes,
`endif
  output logic                 busy
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int MAXL  = (READ_LATENCY > WRITE_LATENCY) ?
                         READ_LATENCY : WRITE_LATENCY;
  localparam int CW    = (MAXL > 1) ? $clog2(MAXL) : 1;

  typedef enum logic [1:0] {
    S_IDLE, S_WAIT, S_RESP, S_TURN
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 op_wr_q, op_wr_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic                 rd_rdy_q, rd_rdy_d;
  logic                 wr_rdy_q, wr_rdy_d;
  logic [DATA_BITS-1:0] rdata_q, rdata_d;
  logic [DATA_BITS-1:0] mem_q [DEPTH];

  // State, latched request and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_wr_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_rdy_q <= 1'b0;
      wr_rdy_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_wr_q  <= op_wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_rdy_q <= rd_rdy_d;
      wr_rdy_q <= wr_rdy_d;
      rdata_q  <= rdata_d;
    end
  end

  // Next-state: accept in IDLE, count down, respond, one turnaround cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (mem_read_valid)
          state_d = (READ_LATENCY > 1) ? S_WAIT : S_RESP;
        else if (mem_write_valid)
          state_d = (WRITE_LATENCY > 1) ? S_WAIT : S_RESP;
      end
      S_WAIT: if (cnt_q == CW'(1)) state_d = S_RESP;
      S_RESP: state_d = S_TURN;
      S_TURN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request latching, counter and next values of the registered outputs
  always_comb begin
    cnt_d    = cnt_q;
    op_wr_d  = op_wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_rdy_d = 1'b0;
    wr_rdy_d = 1'b0;
    rdata_d  = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (mem_read_valid) begin
          op_wr_d = 1'b0;
          addr_d  = mem_read_address;
          cnt_d   = CW'(READ_LATENCY - 1);
        end else if (mem_write_valid) begin
          op_wr_d = 1'b1;
          addr_d  = mem_write_address;
          wdata_d = mem_write_data;
          cnt_d   = CW'(WRITE_LATENCY - 1);
        end
      end
      S_WAIT:  cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (state_d == S_RESP) begin
      if (op_wr_d) begin
        wr_rdy_d = 1'b1;
      end else begin
        rd_rdy_d = 1'b1;
        // a host write landing on this edge is forwarded
        if (host_write_en && host_addr == addr_d)
          rdata_d = host_data;
        else
          rdata_d = mem_q[addr_d];
      end
    end
  end

  // Array: host port first so a same-cycle controller write wins
  always_ff @(posedge clk) begin
    if (host_write_en)
      mem_q[host_addr] <= host_data;
    if (reset && state_q == S_RESP && op_wr_q)
      mem_q[addr_q] <= wdata_q;
  end

  assign mem_read_ready  = rd_rdy_q;
  assign mem_write_ready = wr_rdy_q;
  assign mem_read_data   = rdata_q;
  assign busy            = (state_q != S_IDLE);

`ifdef MEM_RESPONDER_STATS_EN
  logic [15:0] st_rd_q, st_wr_q;

  // Saturating completion counters, bumped in the RESPOND cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      st_rd_q <= '0;
      st_wr_q <= '0;
    end else if (state_q == S_RESP) begin
      if (!op_wr_q && st_rd_q != 16'hFFFF)
        st_rd_q <= st_rd_q + 16'd1;
      if (op_wr_q && st_wr_q != 16'hFFFF)
        st_wr_q <= st_wr_q + 16'd1;
    end
  end

  assign stat_reads  = st_rd_q;
  assign stat_writes = st_wr_q;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder.
// Random requests checked against an array model.
module tb_data_mem_responder;

  localparam int RL = 2;
  localparam int WL = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       mem_read_valid = 1'b0;
  logic [7:0] mem_read_address = '0;
  logic       mem_read_ready;
  logic [7:0] mem_read_data;
  logic       mem_write_valid = 1'b0;
  logic [7:0] mem_write_address = '0;
  logic [7:0] mem_write_data = '0;
  logic       mem_write_ready;
  logic       host_write_en = 1'b0;
  logic [7:0] host_addr = '0;
  logic [7:0] host_data = '0;
  logic       busy;
`ifdef MEM_RESPONDER_STATS_EN
  logic [15:0] stat_reads, stat_writes;
`endif

  data_mem_responder #(
    .ADDR_BITS(8), .DATA_BITS(8),
    .READ_LATENCY(RL), .WRITE_LATENCY(WL)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_read_valid(mem_read_valid),
    .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready),
    .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid),
    .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data),
    .mem_write_ready(mem_write_ready),
    .host_write_en(host_write_en),
    .host_addr(host_addr),
    .host_data(host_data),
`ifdef MEM_RESPONDER_STATS_EN
    .stat_reads(stat_reads),
    .stat_writes(stat_writes),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    bit         wr;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] model [256];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  // Monitor: every ready pulse must match the oldest expected response
  always @(negedge clk) begin
    if (mem_read_ready === 1'b1 || mem_write_ready === 1'b1) begin
      exp_t e;
      chk("both_ready", {31'd0, mem_read_ready & mem_write_ready}, 0);
      if (sbq.size() == 0) begin
        chk("spurious_ready", {30'd0, mem_read_ready, mem_write_ready}, 0);
      end else begin
        e = sbq.pop_front();
        chk("op_kind", {31'd0, mem_write_ready}, {31'd0, e.wr});
        if (!e.wr) chk("read_data", {24'd0, mem_read_data}, {24'd0, e.data});
        chk("ready_cycle", cyc, e.due);
      end
    end
  end

  task automatic wait_ready(bit wr);
    int n = 0;
    logic r;
    do begin
      @(negedge clk);
      n++;
      r = wr ? mem_write_ready : mem_read_ready;
    end while (r !== 1'b1 && n < 50);
    if (r !== 1'b1) chk("ready_timeout", {31'd0, r}, 1);
  endtask

  task automatic host_wr(logic [7:0] a, logic [7:0] d);
    @(posedge clk); #1;
    host_write_en = 1'b1;
    host_addr = a;
    host_data = d;
    @(posedge clk); #1;
    host_write_en = 1'b0;
    model[a] = d;
  endtask

  task automatic do_req(bit wr, logic [7:0] a, logic [7:0] d,
                        bit chk_busy);
    exp_t e;
    @(posedge clk); #1;
    e.wr = wr;
    if (wr) begin
      mem_write_valid = 1'b1;
      mem_write_address = a;
      mem_write_data = d;
      e.data = '0;
      e.due = cyc + WL;
      model[a] = d;
    end else begin
      mem_read_valid = 1'b1;
      mem_read_address = a;
      e.data = model[a];
      e.due = cyc + RL;
    end
    sbq.push_back(e);
    wait_ready(wr);
    if (chk_busy) chk("busy_resp", {31'd0, busy}, 1);
    @(posedge clk); #1;
    mem_read_valid = 1'b0;
    mem_write_valid = 1'b0;
    if (chk_busy) begin
      @(negedge clk);
      chk("busy_turn", {31'd0, busy}, 1);
      @(negedge clk);
      chk("busy_idle", {31'd0, busy}, 0);
    end
  endtask

  task automatic do_both(logic [7:0] ra, logic [7:0] wa, logic [7:0] wd);
    exp_t e;
    @(posedge clk); #1;
    mem_read_valid = 1'b1;
    mem_read_address = ra;
    mem_write_valid = 1'b1;
    mem_write_address = wa;
    mem_write_data = wd;
    e.wr = 1'b0; e.data = model[ra]; e.due = cyc + RL;
    sbq.push_back(e);
    e.wr = 1'b1; e.data = '0; e.due = cyc + RL + 2 + WL;
    sbq.push_back(e);
    model[wa] = wd;
    wait_ready(1'b0);
    @(posedge clk); #1;
    mem_read_valid = 1'b0;
    wait_ready(1'b1);
    @(posedge clk); #1;
    mem_write_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    exp_t e;
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_read_ready", {31'd0, mem_read_ready}, 0);
    chk("rst_write_ready", {31'd0, mem_write_ready}, 0);
    chk("rst_read_data", {24'd0, mem_read_data}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    reset = 1'b1;

    // preload the whole array
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      host_write_en = 1'b1;
      host_addr = 8'(i);
      host_data = 8'($urandom);
      model[i] = host_data;
    end
    @(posedge clk); #1;
    host_write_en = 1'b0;

    // host preload then read
    host_wr(8'h05, 8'hA5);
    do_req(1'b0, 8'h05, 8'h00, 1'b0);

    // write then read back with busy timing
    do_req(1'b1, 8'h10, 8'h3C, 1'b1);
    do_req(1'b0, 8'h10, 8'h00, 1'b1);

    // simultaneous valids: read first, write after turnaround
    do_both(8'h40, 8'h41, 8'hC7);
    do_req(1'b0, 8'h41, 8'h00, 1'b0);
    do_both(8'h42, 8'h42, 8'h6E);
    do_req(1'b0, 8'h42, 8'h00, 1'b0);

    // controller write collides with host write in RESPOND
    @(posedge clk); #1;
    mem_write_valid = 1'b1;
    mem_write_address = 8'h20;
    mem_write_data = 8'h22;
    e.wr = 1'b1; e.data = '0; e.due = cyc + WL;
    sbq.push_back(e);
    repeat (WL) @(posedge clk);
    #1;
    host_write_en = 1'b1;
    host_addr = 8'h20;
    host_data = 8'h11;
    wait_ready(1'b1);
    @(posedge clk); #1;
    host_write_en = 1'b0;
    mem_write_valid = 1'b0;
    model[8'h20] = 8'h22;
    do_req(1'b0, 8'h20, 8'h00, 1'b0);

    // reset while a read waits and a write to 0x30 is pending
    host_wr(8'h30, 8'h77);
    @(posedge clk); #1;
    mem_read_valid = 1'b1;
    mem_read_address = 8'h31;
    mem_write_valid = 1'b1;
    mem_write_address = 8'h30;
    mem_write_data = 8'h99;
    @(posedge clk); #1;
    chk("busy_in_wait", {31'd0, busy}, 1);
    reset = 1'b0;
    mem_read_valid = 1'b0;
    mem_write_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_rdata", {24'd0, mem_read_data}, 0);
    repeat (3) @(posedge clk);
    do_req(1'b0, 8'h30, 8'h00, 1'b0);

    // top address
    do_req(1'b1, 8'hFF, 8'h5A, 1'b0);
    do_req(1'b0, 8'hFF, 8'h00, 1'b0);

    // random mix
    for (int k = 0; k < 80; k++) begin
      int sel = $urandom_range(0, 9);
      logic [7:0] a = 8'($urandom);
      logic [7:0] d = 8'($urandom);
      if (sel < 2) host_wr(a, d);
      else if (sel < 5) do_req(1'b1, a, d, 1'b0);
      else if (sel < 9) do_req(1'b0, a, d, 1'b0);
      else do_both(a, 8'($urandom_range(0, 255)), d);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

`ifdef MEM_RESPONDER_STATS_EN
    do_reset();
    do_req(1'b0, 8'h01, 8'h00, 1'b0);
    do_req(1'b1, 8'h02, 8'h12, 1'b0);
    do_req(1'b0, 8'h02, 8'h00, 1'b0);
    do_req(1'b1, 8'h03, 8'h34, 1'b0);
    do_req(1'b0, 8'h03, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("stat_reads", {16'd0, stat_reads}, 3);
    chk("stat_writes", {16'd0, stat_writes}, 2);
    do_reset();
    chk("stat_reads_rst", {16'd0, stat_reads}, 0);
    chk("stat_writes_rst", {16'd0, stat_writes}, 0);
`endif

    repeat (5) @(posedge clk);
    #1;
    chk("sb_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
